// File: rtl/spi_frame_ctrl_if.sv
// Purpose: bundles the host-side request/response and SPI pad signals of spi_frame_ctrl.
// Latency: none, wires only.
// Backpressure: none; start is only honoured while the controller is idle.
// Ports (master = controller view):
//   start, tx_data, miso        -> into the controller
//   busy, done, rx_data,
//   cs_n, sclk, mosi            <- out of the controller
interface spi_frame_ctrl_if #(
    parameter int FRAME_BITS = 10
);
    logic                  start;
    logic [FRAME_BITS-1:0] tx_data;
    logic                  miso;
    logic                  busy;
    logic                  done;
    logic [FRAME_BITS-1:0] rx_data;
    logic                  cs_n;
    logic                  sclk;
    logic                  mosi;

    modport master (
        input  start, tx_data, miso,
        output busy, done, rx_data, cs_n, sclk, mosi
    );

    modport slave (
        output start, tx_data, miso,
        input  busy, done, rx_data, cs_n, sclk, mosi
    );
endinterface

// File: rtl/spi_frame_ctrl.sv
// Purpose: SPI mode-0 master frame sequencer, FRAME_BITS bits MSB-first per frame.
// Latency: 2*CLK_DIV + 2*FRAME_BITS*CLK_DIV + 1 cycles from accepted start back to idle.
// Backpressure: start is sampled only in IDLE; requests while busy are dropped.
// Ports: clk, rst (async, active high), bus (spi_frame_ctrl_if.master):
//   start/tx_data host request, busy/done/rx_data host status,
//   cs_n/sclk/mosi/miso SPI pads. All outputs are registered.
module spi_frame_ctrl #(
    parameter int FRAME_BITS = 10,
    parameter int CLK_DIV    = 2
) (
    input  logic              clk,
    input  logic              rst,
    spi_frame_ctrl_if.master  bus
);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state_q;
    logic [BW-1:0]         bit_cnt_q;
    logic [DW-1:0]         div_cnt_q;
    logic [FRAME_BITS-1:0] tx_shreg_q;
    logic [FRAME_BITS-1:0] rx_shreg_q;
    logic [FRAME_BITS-1:0] rx_data_q;
    logic                  cs_n_q;
    logic                  sclk_q;
    logic                  mosi_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  div_last;
    logic [FRAME_BITS-1:0] tx_shreg_d;
    logic [FRAME_BITS-1:0] rx_shreg_d;

    // Shifted shift-register values; written via shift + bit insert so that
    // FRAME_BITS=1 elaborates without a zero-width slice.
    always_comb begin
        div_last      = (div_cnt_q == DIV_LAST);
        tx_shreg_d    = tx_shreg_q << 1;
        rx_shreg_d    = rx_shreg_q << 1;
        rx_shreg_d[0] = bus.miso;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            tx_shreg_q <= '0;
            rx_shreg_q <= '0;
            rx_data_q  <= '0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        tx_shreg_q <= bus.tx_data;
                        mosi_q     <= bus.tx_data[FRAME_BITS-1];
                        cs_n_q     <= 1'b0;
                        div_cnt_q  <= '0;
                        bit_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= SETUP;
                    end
                end
                // CS-to-first-edge setup time.
                SETUP: begin
                    if (div_last) begin
                        div_cnt_q <= '0;
                        state_q   <= XFER;
                    end else begin
                        div_cnt_q <= div_cnt_q + DW'(1);
                    end
                end
                XFER: begin
                    if (div_last) begin
                        div_cnt_q <= '0;
                        sclk_q    <= ~sclk_q;
                        if (!sclk_q) begin
                            // Rising edge: slave data is stable, capture it.
                            rx_shreg_q <= rx_shreg_d;
                        end else begin
                            // Falling edge: bit finished, present the next one
                            // or leave mosi on the last bit for the hold phase.
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                            if (bit_cnt_q == BIT_LAST) begin
                                state_q <= HOLD;
                            end else begin
                                tx_shreg_q <= tx_shreg_d;
                                mosi_q     <= tx_shreg_d[FRAME_BITS-1];
                            end
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DW'(1);
                    end
                end
                // CS hold time after the last falling edge.
                HOLD: begin
                    if (div_last) begin
                        div_cnt_q <= '0;
                        cs_n_q    <= 1'b1;
                        done_q    <= 1'b1;
                        rx_data_q <= rx_shreg_q;
                        state_q   <= DONE;
                    end else begin
                        div_cnt_q <= div_cnt_q + DW'(1);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
endmodule
